// File: rtl/fir_pkg.sv
// Shared widths and saturation helpers for the FIR filter and its output paths.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_NUM_TAPS   = 8;
    localparam int FIR_OUT_WIDTH  = 2 * FIR_DATA_WIDTH + $clog2(FIR_NUM_TAPS);

    // Largest value representable in a signed field of the given width.
    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers and a registered head, so the
// consumer sees out_data straight from a flop.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [AW:0]       wr_ptr_s;
    logic [AW:0]       rd_ptr_s;
    logic [AW:0]       level_r;
    logic [AW:0]       level_s;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [WIDTH-1:0]  head_r;
    logic [WIDTH-1:0]  head_s;
    logic              valid_r;
    logic              full_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Next-state pointers, occupancy and head; a push into the slot that becomes head forwards wdata.
    always_comb begin
        pop_ok_s  = pop & valid_r;
        push_ok_s = push & (~full_r | pop_ok_s);
        if (push_ok_s) begin
            wr_ptr_s = wr_ptr_r + (AW+1)'(1'b1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_s = rd_ptr_r + (AW+1)'(1'b1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        level_s = wr_ptr_s - rd_ptr_s;
        if (push_ok_s && (wr_ptr_r[AW-1:0] == rd_ptr_s[AW-1:0])) begin
            head_s = wdata;
        end else begin
            head_s = mem_r[rd_ptr_s[AW-1:0]];
        end
    end

    // Storage, pointers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            level_r  <= level_s;
            valid_r  <= (level_s != {(AW+1){1'b0}});
            full_r   <= (level_s == (AW+1)'(DEPTH));
            head_r   <= head_s;
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            end
        end
    end

    assign rdata = head_r;
    assign valid = valid_r;
    assign full  = full_r;
    assign level = level_r;

endmodule

// File: rtl/fir_output_requant.sv
// FIR output stage: decimate, round-half-up and shift, saturate, then buffer
// behind a valid/ready interface.
module fir_output_requant
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = FIR_OUT_WIDTH,
    parameter int OUT_WIDTH  = FIR_DATA_WIDTH,
    parameter int SHIFT      = 4,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          sat_flag,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SW = IN_WIDTH + 1;
    localparam logic signed [SW-1:0] RND =
        (SHIFT > 0) ? (SW'(1'b1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : SW'(1'b0);
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(OUT_WIDTH));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(OUT_WIDTH));

    logic [PW-1:0]           phase_r;
    logic                    s1_valid_r;
    logic signed [SW-1:0]    s1_data_r;
    logic                    keep_s;
    logic signed [SW-1:0]    ext_s;
    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    shifted_s;
    logic                    clip_s;
    logic [OUT_WIDTH-1:0]    sat_data_s;
    logic                    pop_s;
    logic                    fifo_full_s;
    logic                    sat_flag_r;
    logic                    overflow_r;

    // Rounding uses one guard bit so adding the half-LSB can never wrap.
    always_comb begin
        keep_s    = in_valid & (phase_r == {PW{1'b0}});
        ext_s     = {in_data[IN_WIDTH-1], in_data};
        sum_s     = ext_s + RND;
        shifted_s = sum_s >>> SHIFT;
        pop_s     = out_valid & out_ready;
        if (s1_data_r > SAT_HI) begin
            clip_s     = 1'b1;
            sat_data_s = SAT_HI[OUT_WIDTH-1:0];
        end else if (s1_data_r < SAT_LO) begin
            clip_s     = 1'b1;
            sat_data_s = SAT_LO[OUT_WIDTH-1:0];
        end else begin
            clip_s     = 1'b0;
            sat_data_s = s1_data_r[OUT_WIDTH-1:0];
        end
    end

    // Decimation phase advances only on input strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_r <= {PW{1'b0}};
        end else if (flush) begin
            phase_r <= {PW{1'b0}};
        end else if (in_valid) begin
            if (phase_r == PW'(DECIM - 1)) begin
                phase_r <= {PW{1'b0}};
            end else begin
                phase_r <= phase_r + PW'(1'b1);
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // Stage 1 register holding the rounded, shifted kept sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {SW{1'b0}};
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {SW{1'b0}};
        end else begin
            s1_valid_r <= keep_s;
            if (keep_s) begin
                s1_data_r <= shifted_s;
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

    // Sticky flags; saturation is flagged even when the sample is then dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sat_flag_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (flush) begin
            sat_flag_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (s1_valid_r && clip_s) begin
                sat_flag_r <= 1'b1;
            end else begin
                sat_flag_r <= sat_flag_r;
            end
            if (s1_valid_r && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    fir_sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .flush (flush),
        .push  (s1_valid_r),
        .wdata (sat_data_s),
        .pop   (pop_s),
        .rdata (out_data),
        .valid (out_valid),
        .full  (fifo_full_s),
        .level (level)
    );

    assign sat_flag = sat_flag_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_fir_output_requant.sv
// Scoreboard bench: two instances (DECIM=1 and DECIM=2) checked against an
// arithmetic reference model with an expected-sample queue per instance.
module tb_fir_output_requant;

    localparam int IW  = 35;
    localparam int OW  = 16;
    localparam int SH  = 4;
    localparam int DEP = 4;
    localparam longint DIV = 64'sd1 << SH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          resetn;
    logic [1:0]          in_valid;
    logic [1:0][IW-1:0]  in_data;
    logic [1:0]          flush;
    logic [1:0]          out_ready;
    logic [1:0]          out_valid;
    logic [1:0][OW-1:0]  out_data;
    logic [1:0]          sat_flag;
    logic [1:0]          overflow;
    logic [1:0][2:0]     level;

    fir_output_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(1), .FIFO_DEPTH(DEP)) dut_d1 (
        .clk(clk), .resetn(resetn[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .sat_flag(sat_flag[0]), .overflow(overflow[0]), .level(level[0]));

    fir_output_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(2), .FIFO_DEPTH(DEP)) dut_d2 (
        .clk(clk), .resetn(resetn[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .sat_flag(sat_flag[1]), .overflow(overflow[1]), .level(level[1]));

    int     n_chk  = 0;
    int     n_fail = 0;
    int     mq [2][$];
    int     phase [2];
    bit     pend_v [2];
    longint pend_x [2];
    bit     m_sat [2];
    bit     m_ovf [2];
    int     dec [2] = '{1, 2};

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round half up (floor of x/2^SH + 1/2), then clamp to the output range.
    function automatic int ref_req(input longint x, output bit clip);
        longint v;
        longint q;
        v = x + DIV / 64'sd2;
        if (v >= 64'sd0) q = v / DIV;
        else q = -((-v + DIV - 64'sd1) / DIV);
        clip = 1'b0;
        if (q > 64'sd32767) begin
            q = 64'sd32767;
            clip = 1'b1;
        end else if (q < -64'sd32768) begin
            q = -64'sd32768;
            clip = 1'b1;
        end
        return int'(q);
    endfunction

    function automatic void model_reset(input int d);
        mq[d].delete();
        phase[d]  = 0;
        pend_v[d] = 1'b0;
        pend_x[d] = 64'sd0;
        m_sat[d]  = 1'b0;
        m_ovf[d]  = 1'b0;
    endfunction

    // Compare outputs with the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn[d]) begin
                model_reset(d);
                chk($sformatf("d%0d reset out_valid", d), out_valid[d], 0);
                chk($sformatf("d%0d reset level", d), level[d], 0);
                chk($sformatf("d%0d reset out_data", d), out_data[d], 0);
                chk($sformatf("d%0d reset flags", d), {sat_flag[d], overflow[d]}, 0);
            end else begin
                chk($sformatf("d%0d out_valid", d), out_valid[d], mq[d].size() != 0);
                chk($sformatf("d%0d level", d), level[d], mq[d].size());
                chk($sformatf("d%0d sat_flag", d), sat_flag[d], m_sat[d]);
                chk($sformatf("d%0d overflow", d), overflow[d], m_ovf[d]);
                if (mq[d].size() != 0)
                    chk($sformatf("d%0d out_data", d), longint'($signed(out_data[d])), mq[d][0]);
                if (flush[d]) begin
                    model_reset(d);
                end else begin
                    bit pop;
                    bit clip;
                    int r;
                    pop = (mq[d].size() != 0) && out_ready[d];
                    if (pop) void'(mq[d].pop_front());
                    if (pend_v[d]) begin
                        r = ref_req(pend_x[d], clip);
                        if (clip) m_sat[d] = 1'b1;
                        if (mq[d].size() == DEP) m_ovf[d] = 1'b1;
                        else mq[d].push_back(r);
                    end
                    pend_v[d] = in_valid[d] && (phase[d] == 0);
                    pend_x[d] = longint'($signed(in_data[d]));
                    if (in_valid[d]) phase[d] = (phase[d] + 1) % dec[d];
                end
            end
        end
    end

    // One cycle of stimulus on instance d; the other instance idles.
    task automatic cyc(input int d, input bit v, input longint x, input bit rdy, input bit fl);
        in_valid[d]    = v;
        in_data[d]     = x[IW-1:0];
        out_ready[d]   = rdy;
        flush[d]       = fl;
        in_valid[1-d]  = 1'b0;
        flush[1-d]     = 1'b0;
        out_ready[1-d] = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int d, input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(d, 1'b0, 64'sd0, rdy, 1'b0);
    endtask

    initial begin
        longint lims [4];
        resetn    = 2'b00;
        in_valid  = 2'b00;
        in_data   = '0;
        flush     = 2'b00;
        out_ready = 2'b11;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #2;
        resetn = 2'b11;

        // Rounding: 24 -> 2, -24 -> -1, 7 -> 0
        cyc(0, 1'b1, 64'sd24, 1'b1, 1'b0);
        cyc(0, 1'b1, -64'sd24, 1'b1, 1'b0);
        cyc(0, 1'b1, 64'sd7, 1'b1, 1'b0);
        idle(0, 4, 1'b1);

        // Saturation extremes and the exact clip boundaries
        lims = '{64'sd524279, 64'sd524280, -64'sd524296, -64'sd524297};
        cyc(0, 1'b1, 64'sd1 << 20, 1'b1, 1'b0);
        cyc(0, 1'b1, -(64'sd1 << 20), 1'b1, 1'b0);
        idle(0, 2, 1'b1);
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, lims[i], 1'b1, 1'b0);
        idle(0, 4, 1'b1);

        // Decimation by 2 with idle gaps between strobes
        cyc(1, 1'b1, 64'sd16, 1'b1, 1'b0);
        cyc(1, 1'b0, 64'sd0, 1'b1, 1'b0);
        cyc(1, 1'b1, 64'sd32, 1'b1, 1'b0);
        idle(1, 2, 1'b1);
        cyc(1, 1'b1, 64'sd48, 1'b1, 1'b0);
        cyc(1, 1'b1, 64'sd64, 1'b1, 1'b0);
        idle(1, 4, 1'b1);

        // Backpressure and overflow, then a drain with stalls in between
        cyc(0, 1'b0, 64'sd0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) cyc(0, 1'b1, 64'sd16 * i, 1'b0, 1'b0);
        idle(0, 3, 1'b0);
        for (int i = 0; i < 8; i++) cyc(0, 1'b0, 64'sd0, i[0], 1'b0);
        idle(0, 2, 1'b1);

        // Full FIFO with push and pop on the same edge
        cyc(0, 1'b0, 64'sd0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(0, 1'b1, 64'sd16 * i, 1'b0, 1'b0);
        cyc(0, 1'b1, 64'sd160, 1'b0, 1'b0);
        cyc(0, 1'b0, 64'sd0, 1'b1, 1'b0);
        idle(0, 2, 1'b0);
        idle(0, 6, 1'b1);

        // Flush mid-stream with level 3 and phase 1; coincident strobe is discarded
        for (int i = 1; i <= 5; i++) cyc(1, 1'b1, 64'sd16 * i, 1'b0, 1'b0);
        idle(1, 1, 1'b0);
        cyc(1, 1'b1, 64'sd99, 1'b0, 1'b1);
        cyc(1, 1'b1, 64'sd16, 1'b1, 1'b0);
        idle(1, 4, 1'b1);

        // Asynchronous reset pulse between edges
        for (int i = 1; i <= 5; i++) cyc(1, 1'b1, 64'sd1 << 21, 1'b0, 1'b0);
        idle(1, 1, 1'b0);
        resetn[1] = 1'b0;
        #1;
        chk("async reset out_valid", out_valid[1], 0);
        chk("async reset level", level[1], 0);
        chk("async reset out_data", out_data[1], 0);
        chk("async reset sat_flag", sat_flag[1], 0);
        model_reset(1);
        #1;
        resetn[1] = 1'b1;
        @(posedge clk);
        #2;
        cyc(1, 1'b1, 64'sd32, 1'b1, 1'b0);
        idle(1, 4, 1'b1);

        // Randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                longint x;
                logic [63:0] raw;
                case ($urandom_range(0, 3))
                    0: x = longint'($urandom_range(0, 2000)) - 64'sd1000;
                    1: x = longint'($urandom_range(0, 1 << 20)) - (64'sd1 << 19);
                    2: x = longint'($urandom_range(0, 1 << 22)) - (64'sd1 << 21);
                    default: begin
                        raw = {$urandom(), $urandom()};
                        x = longint'($signed(raw[IW-1:0]));
                    end
                endcase
                in_valid[d]  = ($urandom_range(0, 99) < 60);
                in_data[d]   = x[IW-1:0];
                out_ready[d] = ($urandom_range(0, 99) < 70);
                flush[d]     = ($urandom_range(0, 99) < 2);
            end
            @(posedge clk);
            #2;
        end
        in_valid  = 2'b00;
        flush     = 2'b00;
        out_ready = 2'b11;
        repeat (8) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
